enc_conditioner: RTL and testbench

ENC_CONDITIONER -- requirements
Module: enc_conditioner

---
 rtl/enc_pkg.sv | 27 ++
 rtl/enc_glitch_filter.sv | 46 ++++
 rtl/enc_conditioner.sv | 115 +++++++++++
 tb/tb_enc_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and quadrature transition classification for the encoder conditioner.
package enc_pkg;

  localparam int POS_W_DEF    = 16;
  localparam int FILT_CNT_DEF = 4;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_FWD  = 2'd1,
    TR_REV  = 2'd2,
    TR_ILL  = 2'd3
  } trans_e;

  // Pairs are {A,B}; forward order is 00->10->11->01->00.
  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return TR_FWD;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return TR_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: return TR_ILL;
      default:                            return TR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// One encoder channel: 2-FF synchronizer followed by a stable-count glitch filter.
module enc_glitch_filter import enc_pkg::*; #(
  parameter int FILT_CNT = FILT_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [7:0] CNT_LAST = 8'(FILT_CNT - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [7:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the output restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/enc_conditioner.sv
// Quadrature encoder front end: filtered channels, step/dir decode, position count and
// sticky illegal-transition flag, with a settling window after reset.
module enc_conditioner import enc_pkg::*; #(
  parameter int FILT_CNT = FILT_CNT_DEF,
  parameter int POS_W    = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             encA_raw,
  input  logic             encB_raw,
  input  logic             pos_clr,
  input  logic             err_clr,
  output logic             encA,
  output logic             encB,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             err,
  output logic             ready
);

  localparam logic [8:0]       SETTLE_LAST = 9'(FILT_CNT + 2);
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

  logic [1:0] raw_vec, filt_vec;
  assign raw_vec = {encA_raw, encB_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      enc_glitch_filter #(.FILT_CNT(FILT_CNT)) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (raw_vec[gi]),
        .filt_o (filt_vec[gi])
      );
    end
  endgenerate

  logic [1:0]       prev_q, prev_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic [8:0]       settle_q, settle_d;
  trans_e           tr;

  assign tr = classify(prev_q, filt_vec);

  // Until ready, prev simply tracks the filtered pair so settling edges are ignored.
  always_comb begin
    prev_d   = filt_vec;
    step_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    err_d    = err_clr ? 1'b0 : err_q;
    ready_d  = ready_q;
    settle_d = settle_q;
    if (!ready_q) begin
      if (settle_q == SETTLE_LAST) begin
        ready_d = 1'b1;
      end else begin
        settle_d = settle_q + 9'd1;
      end
    end else begin
      case (tr)
        TR_FWD: begin
          step_d = 1'b1;
          dir_d  = DIR_FWD;
          pos_d  = pos_q + POS_ONE;
        end
        TR_REV: begin
          step_d = 1'b1;
          dir_d  = DIR_REV;
          pos_d  = pos_q - POS_ONE;
        end
        TR_ILL:  err_d = 1'b1;
        default: ;
      endcase
    end
    if (pos_clr) begin
      pos_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= 2'b00;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      prev_q   <= prev_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      settle_q <= settle_d;
    end
  end

  assign encA  = filt_vec[1];
  assign encB  = filt_vec[0];
  assign step  = step_q;
  assign dir   = dir_q;
  assign pos   = pos_q;
  assign err   = err_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_enc_conditioner.sv
// Directed bench for enc_conditioner: per-cycle vector table for reset/settling/glitch,
// then hand-written quadrature, wrap, clear-priority and mid-operation reset sequences.
module tb_enc_conditioner;

  logic        clk;
  logic        rst_n;
  logic        encA_raw, encB_raw;
  logic        pos_clr, err_clr;
  logic        encA, encB, step, dir, err, ready;
  logic [15:0] pos;

  enc_conditioner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .encA_raw (encA_raw),
    .encB_raw (encB_raw),
    .pos_clr  (pos_clr),
    .err_clr  (err_clr),
    .encA     (encA),
    .encB     (encB),
    .step     (step),
    .dir      (dir),
    .pos      (pos),
    .err      (err),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic exp_a;
    logic exp_b;
    logic exp_step;
    logic exp_ready;
    logic exp_err;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  logic        cur_a, cur_b;
  logic [15:0] exp_pos;
  logic        exp_dir;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, a, b, ea, eb, est, erdy, eerr);
    vec_t v;
    v.rst_n = r; v.a_raw = a; v.b_raw = b;
    v.exp_a = ea; v.exp_b = eb; v.exp_step = est; v.exp_ready = erdy; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  // Apply a new raw pair and watch a 20-cycle window; optional clears land on the edge
  // where the resulting step/err is registered (edge 7 for FILT_CNT=4).
  task automatic move(input logic na, input logic nb, input bit clr7, input bit eclr7,
                      input int exp_steps, input string nm);
    int nsteps;
    int first;
    nsteps = 0;
    first  = -1;
    encA_raw = na;
    encB_raw = nb;
    for (int e = 1; e <= 20; e++) begin
      if (e == 7) begin
        pos_clr = clr7;
        err_clr = eclr7;
      end
      tick();
      if (e == 7) begin
        pos_clr = 1'b0;
        err_clr = 1'b0;
      end
      if (step === 1'b1) begin
        nsteps++;
        if (first < 0) first = e;
      end
    end
    check({nm, "_steps"}, nsteps, exp_steps);
    if (exp_steps == 1) check({nm, "_lat"}, first, 7);
    cur_a = na;
    cur_b = nb;
    $display("move %s: raw=%b%b steps=%0d pos=%h dir=%b err=%b", nm, na, nb, nsteps, pos, dir, err);
  endtask

  task automatic fwd(input bit clr7, input string nm);
    move(~cur_b, cur_a, clr7, 1'b0, 1, nm);
    exp_pos = clr7 ? 16'h0000 : exp_pos + 16'd1;
    exp_dir = 1'b1;
    check({nm, "_pos"}, pos, exp_pos);
    check({nm, "_dir"}, dir, exp_dir);
  endtask

  task automatic rev(input string nm);
    move(cur_b, ~cur_a, 1'b0, 1'b0, 1, nm);
    exp_pos = exp_pos - 16'd1;
    exp_dir = 1'b0;
    check({nm, "_pos"}, pos, exp_pos);
    check({nm, "_dir"}, dir, exp_dir);
  endtask

  initial begin
    int rdy_edge;
    rst_n = 1'b0; encA_raw = 1'b0; encB_raw = 1'b0; pos_clr = 1'b0; err_clr = 1'b0;

    // Reset held with A,B=11, then release: filtered at edge 6, ready at edge 7.
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 8; e++) add(1, 1, 1, e >= 6, e >= 6, 0, e >= 7, 0);
    // Reset again with A,B=00, settle, then a 3-cycle high glitch on A.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 8; e++) add(1, 0, 0, 0, 0, 0, e >= 7, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) add(1, 0, 0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      encA_raw = vecs[i].a_raw;
      encB_raw = vecs[i].b_raw;
      tick();
      check($sformatf("v%0d_encA", i), encA, vecs[i].exp_a);
      check($sformatf("v%0d_encB", i), encB, vecs[i].exp_b);
      check($sformatf("v%0d_step", i), step, vecs[i].exp_step);
      check($sformatf("v%0d_ready", i), ready, vecs[i].exp_ready);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_pos", i), pos, 16'h0000);
      $display("vec %0d: rst_n=%b raw=%b%b -> encA=%b encB=%b step=%b ready=%b err=%b pos=%h",
               i, rst_n, encA_raw, encB_raw, encA, encB, step, ready, err, pos);
    end

    cur_a = 1'b0; cur_b = 1'b0; exp_pos = 16'h0000; exp_dir = 1'b0;

    for (int i = 0; i < 8; i++) fwd(1'b0, $sformatf("fwd%0d", i));
    check("fwd8_pos", pos, 16'h0008);
    for (int i = 0; i < 10; i++) rev($sformatf("rev%0d", i));
    check("rev10_pos", pos, 16'hFFFE);
    check("rev10_dir", dir, 1'b0);

    fwd(1'b0, "wrap_a");
    check("wrap_ffff", pos, 16'hFFFF);
    fwd(1'b0, "wrap_b");
    check("wrap_zero", pos, 16'h0000);
    fwd(1'b0, "pre_ill");

    // Both channels flip together: illegal, pos and dir hold.
    move(~cur_a, ~cur_b, 1'b0, 1'b0, 0, "ill1");
    check("ill1_err", err, 1'b1);
    check("ill1_pos", pos, exp_pos);
    check("ill1_dir", dir, exp_dir);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr_alone", err, 1'b0);
    tick();
    check("errclr_hold", err, 1'b0);

    move(~cur_a, ~cur_b, 1'b0, 1'b1, 0, "ill2");
    check("ill2_setwins", err, 1'b1);
    check("ill2_pos", pos, exp_pos);

    fwd(1'b1, "clr_step");
    fwd(1'b0, "pre_rst");

    // Start another transition, then reset while its filter count is in progress.
    encA_raw = ~cur_b;
    encB_raw = cur_a;
    cur_a = encA_raw;
    cur_b = encB_raw;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    check("rst_encA", encA, 1'b0);
    check("rst_encB", encB, 1'b0);
    check("rst_step", step, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_pos", pos, 16'h0000);
    check("rst_err", err, 1'b0);
    check("rst_ready", ready, 1'b0);
    $display("midrst: encA=%b encB=%b pos=%h err=%b ready=%b", encA, encB, pos, err, ready);
    rst_n = 1'b1;
    rdy_edge = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (ready === 1'b1 && rdy_edge < 0) rdy_edge = e;
    end
    check("rst_ready_edge", rdy_edge, 7);
    check("rst_final_encA", encA, cur_a);
    check("rst_final_encB", encB, cur_b);
    check("rst_final_err", err, 1'b0);
    $display("release: ready_edge=%0d encA=%b encB=%b", rdy_edge, encA, encB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
